// File: rtl/sram_display_arbiter.sv
// Arbitrates the single off-chip SRAM between the VGA display (absolute priority)
// and the HDR core, which only gets single-cycle slots the display has declared free.
module sram_display_arbiter #(
    parameter int BURST_MAX = 16
) (
    input  logic        i_clk_25M,
    input  logic        i_rst_n,
    input  logic        i_display_en,
    input  logic        i_disp_busy,
    input  logic [19:0] i_addr_display,
    output logic [15:0] o_pixel_value,
    input  logic        i_core_req,
    input  logic        i_core_we,
    input  logic [19:0] i_core_addr,
    input  logic [15:0] i_core_wdata,
    output logic        o_core_ack,
    output logic        o_core_rvalid,
    output logic [15:0] o_core_rdata,
    output logic [19:0] o_SRAM_ADDR,
    inout  wire  [15:0] io_SRAM_DQ,
    output logic        o_SRAM_WE_N,
    output logic        o_SRAM_CE_N,
    output logic        o_SRAM_OE_N,
    output logic        o_SRAM_LB_N,
    output logic        o_SRAM_UB_N
);

    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        S_DISP,
        S_CORE_RD,
        S_CORE_WR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic [19:0]   core_addr_q, core_addr_d;
    logic [15:0]   core_wdata_q, core_wdata_d;
    logic          core_we_q, core_we_d;
    logic [15:0]   pixel_q, pixel_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          grant;

    // The busy lookahead means a grant here never collides with a display cycle next.
    assign grant = i_rst_n && i_core_req && !(i_display_en && i_disp_busy)
                   && (burst_cnt_q < CW'(BURST_MAX));

    always_comb begin
        state_d      = S_DISP;
        burst_cnt_d  = '0;
        core_addr_d  = core_addr_q;
        core_wdata_d = core_wdata_q;
        core_we_d    = core_we_q;
        pixel_d      = pixel_q;
        rdata_d      = rdata_q;
        rvalid_d     = (state_q == S_CORE_RD);

        if (state_q == S_DISP) begin
            pixel_d = io_SRAM_DQ;
        end
        if (state_q == S_CORE_RD) begin
            rdata_d = io_SRAM_DQ;
        end

        if (grant) begin
            core_addr_d  = i_core_addr;
            core_wdata_d = i_core_wdata;
            core_we_d    = i_core_we;
            state_d      = i_core_we ? S_CORE_WR : S_CORE_RD;
            burst_cnt_d  = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_DISP;
            burst_cnt_q  <= '0;
            core_addr_q  <= '0;
            core_wdata_q <= '0;
            core_we_q    <= 1'b0;
            pixel_q      <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_cnt_q  <= burst_cnt_d;
            core_addr_q  <= core_addr_d;
            core_wdata_q <= core_wdata_d;
            core_we_q    <= core_we_d;
            pixel_q      <= pixel_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    // Pin decode comes straight off the state register so a reset aborts a write at once.
    assign o_SRAM_ADDR   = (state_q == S_DISP) ? i_addr_display : core_addr_q;
    assign o_SRAM_WE_N   = (state_q != S_CORE_WR);
    assign o_SRAM_OE_N   = (state_q == S_CORE_WR);
    assign o_SRAM_CE_N   = 1'b0;
    assign o_SRAM_LB_N   = 1'b0;
    assign o_SRAM_UB_N   = 1'b0;
    assign io_SRAM_DQ    = (state_q == S_CORE_WR) ? core_wdata_q : 16'hzzzz;

    assign o_pixel_value = (state_q == S_DISP) ? io_SRAM_DQ : pixel_q;
    assign o_core_ack    = grant;
    assign o_core_rvalid = rvalid_q;
    assign o_core_rdata  = rdata_q;

endmodule
